// File: rtl/dtree_pkg.sv
// rtl/dtree_pkg.sv - shared sizes, state encoding and feature positions for the decision-tree loader
package dtree_pkg;
  localparam int NUM_FEATURES = 5;
  localparam int FEAT_W       = 8;
  localparam int CLASS_W      = 5;

  typedef enum logic [1:0] {LOAD, EVAL, RESULT, DRAIN} state_t;

  localparam int F_X13  = 0;
  localparam int F_X27  = 1;
  localparam int F_X235 = 2;
  localparam int F_X264 = 3;
  localparam int F_X278 = 4;
endpackage

// File: rtl/dtree_feat_regs.sv
// rtl/dtree_feat_regs.sv - indexed feature slots with a committed, flattened feature bus
// Slots take bytes as they arrive; feat_bus only changes on commit, so the tree never sees a partial frame.
module dtree_feat_regs #(
  parameter int NUM_FEATURES = 5,
  parameter int FEAT_W       = 8,
  parameter int IDX_W        = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [IDX_W-1:0]               wr_idx,
  input  logic [FEAT_W-1:0]              wr_data,
  input  logic                           commit,
  output logic [NUM_FEATURES*FEAT_W-1:0] feat_bus
);
  logic [FEAT_W-1:0] slots [NUM_FEATURES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FEATURES; i++) slots[i] <= '0;
      feat_bus <= '0;
    end else begin
      if (wr_en) slots[wr_idx] <= wr_data;
      // The closing byte is merged in directly since its slot write lands in the same edge.
      if (commit) begin
        for (int i = 0; i < NUM_FEATURES; i++)
          feat_bus[i*FEAT_W +: FEAT_W] <= (wr_en && wr_idx == IDX_W'(i)) ? wr_data : slots[i];
      end
    end
  end
endmodule

// File: rtl/dtree_frame_loader.sv
// rtl/dtree_frame_loader.sv - byte-serial frame loader and result sequencer for a combinational dtree
// Optional partial-frame idle timeout: DTREE_LOADER_TIMEOUT_EN.
module dtree_frame_loader
  import dtree_pkg::*;
#(
  parameter int NUM_FEATURES   = dtree_pkg::NUM_FEATURES,
  parameter int FEAT_W         = dtree_pkg::FEAT_W,
  parameter int CLASS_W        = dtree_pkg::CLASS_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [FEAT_W-1:0]              s_data,
  input  logic                           s_last,
  output logic [NUM_FEATURES*FEAT_W-1:0] feat_bus,
  input  logic [CLASS_W-1:0]             cls_in,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [CLASS_W-1:0]             m_class,
  output logic                           m_err
);
  localparam int IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             wr_en;
  logic             commit;
  logic             timeout;

  assign accept = s_valid && s_ready;
  assign wr_en  = accept && (state == LOAD);
  assign commit = wr_en && s_last && (idx == LAST_IDX);

`ifdef DTREE_LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] idle_cnt;

  assign timeout = (state == LOAD) && (idx != '0) && !accept &&
                   (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || state != LOAD || accept || idx == '0) idle_cnt <= '0;
    else                                            idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  dtree_feat_regs #(
    .NUM_FEATURES(NUM_FEATURES),
    .FEAT_W      (FEAT_W),
    .IDX_W       (IDX_W)
  ) u_feat_regs (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (idx),
    .wr_data (s_data),
    .commit  (commit),
    .feat_bus(feat_bus)
  );

  // s_ready and m_valid are registered from the next state so neither depends on the handshake inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOAD;
      idx     <= '0;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      m_class <= '0;
      m_err   <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          s_ready <= 1'b1;
          if (timeout || (accept && s_last && idx != LAST_IDX)) begin
            state   <= RESULT;
            idx     <= '0;
            s_ready <= 1'b0;
            m_valid <= 1'b1;
            m_class <= '0;
            m_err   <= 1'b1;
          end else if (accept && idx == LAST_IDX) begin
            idx <= '0;
            if (s_last) begin
              state   <= EVAL;
              s_ready <= 1'b0;
            end else begin
              state <= DRAIN;
            end
          end else if (accept) begin
            idx <= idx + 1'b1;
          end
        end
        EVAL: begin
          state   <= RESULT;
          m_valid <= 1'b1;
          m_class <= cls_in;
          m_err   <= 1'b0;
        end
        RESULT: begin
          if (m_ready) begin
            state   <= LOAD;
            m_valid <= 1'b0;
            s_ready <= 1'b1;
          end
        end
        DRAIN: begin
          if (accept && s_last) begin
            state   <= RESULT;
            s_ready <= 1'b0;
            m_valid <= 1'b1;
            m_class <= '0;
            m_err   <= 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_dtree_frame_loader.sv
// tb/tb_dtree_frame_loader.sv - self-checking bench for dtree_frame_loader against a frame-level model
module tb_dtree_frame_loader;
  localparam int N  = 5;
  localparam int FW = 8;
  localparam int CW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            s_valid;
  logic            s_ready;
  logic [FW-1:0]   s_data;
  logic            s_last;
  logic [N*FW-1:0] feat_bus;
  logic [CW-1:0]   cls_in;
  logic            m_valid;
  logic            m_ready;
  logic [CW-1:0]   m_class;
  logic            m_err;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]      fb [16];
  logic [N*FW-1:0] exp_feat;

  always #5 clk = ~clk;

  // Stand-in tree: class is the top five bits of X278.
  assign cls_in = feat_bus[N*FW-1 -: CW];

  dtree_frame_loader #(.TIMEOUT_CYCLES(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .feat_bus(feat_bus),
    .cls_in  (cls_in),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_class (m_class),
    .m_err   (m_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l);
    int w = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (s_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    check("s_ready_wait", 64'(w), 64'd0);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Sends fb[first..len-1] with s_last on the final byte, then checks and retires the result.
  task automatic do_frame(input int len, input int first, input int hold, input bit gaps);
    int w;
    logic [CW-1:0] ec;
    logic          ee;
    bit            good;
    good = (len == N);
    if (good) begin
      for (int i = 0; i < N; i++) exp_feat[i*FW +: FW] = fb[i];
      ec = fb[N-1][7:3];
      ee = 1'b0;
    end else begin
      ec = '0;
      ee = 1'b1;
    end
    for (int i = first; i < len; i++) begin
      push_byte(fb[i], i == len - 1);
      if (gaps && i != len - 1) repeat ($urandom_range(0, 1)) tick();
    end
    w = 0;
    while (m_valid !== 1'b1 && w < 10) begin
      tick();
      w++;
    end
    check("result_latency", 64'(w), good ? 64'd1 : 64'd0);
    check("m_class", 64'(m_class), 64'(ec));
    check("m_err", 64'(m_err), 64'(ee));
    check("feat_bus", 64'(feat_bus), 64'(exp_feat));
    for (int h = 0; h < hold; h++) begin
      s_valid = 1'b1;
      s_data  = 8'hA5;
      tick();
      check("hold_m_valid", 64'(m_valid), 64'd1);
      check("hold_m_class", 64'(m_class), 64'(ec));
      check("hold_s_ready", 64'(s_ready), 64'd0);
    end
    if (hold > 0) check("hold_idx", 64'(dut.idx), 64'd0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    s_valid = 1'b0;
    check("post_m_valid", 64'(m_valid), 64'd0);
    check("post_s_ready", 64'(s_ready), 64'd1);
  endtask

  initial begin
    int len;
    int w;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    exp_feat = '0;
    tick();
    tick();
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_class", 64'(m_class), 64'd0);
    check("rst_m_err", 64'(m_err), 64'd0);
    check("rst_feat_bus", 64'(feat_bus), 64'd0);
    check("rst_idx", 64'(dut.idx), 64'd0);
    rst = 1'b0;
    tick();
    check("rst_release_s_ready", 64'(s_ready), 64'd1);

    fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33; fb[3] = 8'h44; fb[4] = 8'hF8;
    do_frame(5, 0, 0, 1'b0);
    check("frame1_feat", 64'(feat_bus), 64'hF844332211);

    fb[0] = 8'h01; fb[1] = 8'h02; fb[2] = 8'h03;
    do_frame(3, 0, 0, 1'b0);
    fb[0] = 8'h55; fb[1] = 8'h66; fb[2] = 8'h77; fb[3] = 8'h88; fb[4] = 8'h40;
    do_frame(5, 0, 0, 1'b0);
    check("frame_x278_40", 64'(m_class), 64'h08);

    for (int i = 0; i < 6; i++) fb[i] = 8'(8'h90 + i);
    do_frame(6, 0, 0, 1'b0);

    fb[0] = 8'h12; fb[1] = 8'h34; fb[2] = 8'h56; fb[3] = 8'h78; fb[4] = 8'hC3;
    do_frame(5, 0, 10, 1'b0);

    push_byte(8'hDE, 1'b0);
    push_byte(8'hAD, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_feat = '0;
    check("midrst_idx", 64'(dut.idx), 64'd0);
    check("midrst_m_valid", 64'(m_valid), 64'd0);
    check("midrst_feat_bus", 64'(feat_bus), 64'd0);
    tick();
    fb[0] = 8'hA1; fb[1] = 8'hB2; fb[2] = 8'hC3; fb[3] = 8'hD4; fb[4] = 8'h9F;
    do_frame(5, 0, 0, 1'b0);

    fb[0] = 8'h0A; fb[1] = 8'h0B; fb[2] = 8'h0C; fb[3] = 8'h0D; fb[4] = 8'h70;
    push_byte(fb[0], 1'b0);
    push_byte(fb[1], 1'b0);
`ifdef DTREE_LOADER_TIMEOUT_EN
    w = 0;
    while (m_valid !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    check("timeout_cycles", 64'(w), 64'd4);
    check("timeout_m_err", 64'(m_err), 64'd1);
    check("timeout_m_class", 64'(m_class), 64'd0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("timeout_idx", 64'(dut.idx), 64'd0);
    do_frame(5, 0, 0, 1'b0);
`else
    w = 0;
    repeat (20) begin
      tick();
      if (m_valid === 1'b1) w++;
    end
    check("no_timeout_m_valid", 64'(w), 64'd0);
    do_frame(5, 2, 0, 1'b0);
`endif

    for (int f = 0; f < 25; f++) begin
      case ($urandom_range(0, 3))
        0:       len = $urandom_range(1, N - 1);
        1:       len = $urandom_range(N + 1, N + 4);
        default: len = N;
      endcase
      for (int i = 0; i < len; i++) fb[i] = 8'($urandom);
      do_frame(len, 0, $urandom_range(0, 3), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
